// File: rtl/mdr_pkg.sv
// Shared types and constants for the multiply/divide/sqrt sequencer.
// Optional square-root support is enabled by defining MDR_SEQ_SQRT_EN.
package mdr_pkg;

    localparam int unsigned DEFAULT_ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StIter,
        StStore,
        StDone
    } state_e;

    function automatic logic op_valid(input logic [1:0] op);
`ifdef MDR_SEQ_SQRT_EN
        return op != OP_RSVD;
`else
        return (op == OP_MULT) || (op == OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// Iteration index counter: counts 0..terminal while enabled, then wraps to 0.
module mdr_iter_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    assign last = (count == terminal);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mdr_sequencer.sv
// Control sequencer for an iterative multiply/divide/sqrt datapath.
// Define MDR_SEQ_SQRT_EN to enable op=10 (sqrt, ITERATIONS/2 steps); otherwise it is reserved.
module mdr_sequencer
    import mdr_pkg::*;
#(
    parameter int unsigned ITERATIONS = DEFAULT_ITERATIONS,
    localparam int unsigned IDX_W = $clog2(ITERATIONS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic             divisor_zero,
    output logic             sys_clr,
    output logic             load_en,
    output logic             iter_en,
    output logic             result_en,
    output logic [IDX_W-1:0] iter_idx,
    output logic [1:0]       op_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [1:0]       op_d;
    logic             err_d;
    logic             sys_clr_q, load_en_q, iter_en_q, result_en_q;
    logic             abort_hit, dz_fail, last;
    logic [IDX_W-1:0] terminal;

    // Abort only matters while an operation is actually in flight.
    assign abort_hit = abort && (state_q inside {StClear, StLoad, StIter, StStore});
    assign dz_fail   = (state_q == StIter) && (iter_idx == '0) && (op_q == OP_DIV)
                       && divisor_zero;

`ifdef MDR_SEQ_SQRT_EN
    assign terminal = (op_q == OP_SQRT) ? IDX_W'(ITERATIONS / 2 - 1) : IDX_W'(ITERATIONS - 1);
`else
    assign terminal = IDX_W'(ITERATIONS - 1);
`endif

    mdr_iter_counter #(
        .WIDTH (IDX_W)
    ) u_iter_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state_q != StIter) || abort_hit || dz_fail),
        .enable   (state_q == StIter),
        .terminal (terminal),
        .count    (iter_idx),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op_valid(op)) begin
                        state_d = StClear;
                        op_d    = op;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StClear: state_d = StLoad;
            StLoad:  state_d = StIter;
            StIter: begin
                if (dz_fail) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (last) begin
                    state_d = StStore;
                end
            end
            StStore: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_hit) begin
            state_d = StIdle;
        end
    end

    // Strobes and flags are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            err         <= 1'b0;
            sys_clr_q   <= 1'b0;
            load_en_q   <= 1'b0;
            iter_en_q   <= 1'b0;
            result_en_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            err         <= err_d;
            sys_clr_q   <= (state_d == StClear);
            load_en_q   <= (state_d == StLoad);
            iter_en_q   <= (state_d == StIter);
            result_en_q <= (state_d == StStore);
            busy        <= (state_d != StIdle);
            done        <= (state_d == StDone);
        end
    end

    // Abort and a zero divisor must act within the cycle they are seen.
    assign sys_clr   = sys_clr_q | abort_hit;
    assign load_en   = load_en_q & ~abort_hit;
    assign iter_en   = iter_en_q & ~abort_hit & ~dz_fail;
    assign result_en = result_en_q & ~abort_hit;

endmodule

// File: tb/tb_mdr_sequencer.sv
// Scoreboard bench for mdr_sequencer: expected per-operation results are queued at start.
module tb_mdr_sequencer;
    import mdr_pkg::*;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned IDX_W = $clog2(ITERATIONS);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             abort = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             sys_clr, load_en, iter_en, result_en;
    logic [IDX_W-1:0] iter_idx;
    logic [1:0]       op_q;
    logic             busy, done, err;

    typedef struct {
        int latency;
        int err;
        int clrs;
        int loads;
        int iters;
        int results;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    mdr_sequencer #(
        .ITERATIONS (ITERATIONS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .abort        (abort),
        .divisor_zero (divisor_zero),
        .sys_clr      (sys_clr),
        .load_en      (load_en),
        .iter_en      (iter_en),
        .result_en    (result_en),
        .iter_idx     (iter_idx),
        .op_q         (op_q),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic exp_t mk(input int lat, input int e, input int c, input int l,
                                input int i, input int r);
        exp_t x;
        x.latency = lat;
        x.err     = e;
        x.clrs    = c;
        x.loads   = l;
        x.iters   = i;
        x.results = r;
        return x;
    endfunction

    function automatic int all_outs();
        return int'({sys_clr, load_en, iter_en, result_en, busy, done, err, op_q, iter_idx});
    endfunction

    // Launch one op, tally strobes each cycle, compare against the queued entry on done.
    task automatic run_op(input string name, input logic [1:0] o, input logic dz, input exp_t e,
                          input int repulse_at);
        int   k = 1;
        int   clrs = 0, loads = 0, iters = 0, results = 0;
        bit   seen = 0;
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        op = o;
        divisor_zero = dz;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 2'b11;
        while (!seen && k <= 100) begin
            check_val({name, "_onehot"}, int'(sys_clr) + int'(load_en) + int'(iter_en)
                      + int'(result_en) > 1 ? 1 : 0, 0);
            if (iter_en) begin
                check_val({name, "_idx"}, int'(iter_idx), iters);
                iters++;
            end
            if (result_en) begin
                check_val({name, "_store_idx"}, int'(iter_idx), 0);
                results++;
            end
            if (sys_clr) clrs++;
            if (load_en) loads++;
            if (k == repulse_at) begin
                start = 1'b1;
                op = OP_MULT;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                x = sb_q.pop_front();
                check_val({name, "_latency"}, k, x.latency);
                check_val({name, "_err"}, int'(err), x.err);
                check_val({name, "_clrs"}, clrs, x.clrs);
                check_val({name, "_loads"}, loads, x.loads);
                check_val({name, "_iters"}, iters, x.iters);
                check_val({name, "_results"}, results, x.results);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check_val({name, "_done_timeout"}, 0, 1);
            sb_q.delete();
        end else begin
            @(negedge clk);
            check_val({name, "_done_pulse"}, int'(done), 0);
            check_val({name, "_idle_busy"}, int'(busy), 0);
            check_val({name, "_err_hold"}, int'(err), x.err);
        end
        divisor_zero = 1'b0;
    endtask

    task automatic launch_mult_to(input int idx);
        @(negedge clk);
        start = 1'b1;
        op = OP_MULT;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !(iter_en && int'(iter_idx) == idx); i++) @(negedge clk);
        check_val("reach_idx", int'(iter_idx), idx);
    endtask

    initial begin
        bit done_seen;
        repeat (2) @(negedge clk);
        check_val("reset_outs", all_outs(), 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("post_reset_outs", all_outs(), 0);

        run_op("mult", OP_MULT, 1'b0, mk(36, 0, 1, 1, 32, 1), 0);
        run_op("div", OP_DIV, 1'b0, mk(36, 0, 1, 1, 32, 1), 0);
        run_op("div_zero", OP_DIV, 1'b1, mk(4, 1, 1, 1, 0, 0), 0);
`ifdef MDR_SEQ_SQRT_EN
        run_op("sqrt", OP_SQRT, 1'b0, mk(20, 0, 1, 1, 16, 1), 0);
`else
        run_op("sqrt", OP_SQRT, 1'b0, mk(1, 1, 0, 0, 0, 0), 0);
`endif
        run_op("rsvd", OP_RSVD, 1'b0, mk(1, 1, 0, 0, 0, 0), 0);
        run_op("repulse", OP_MULT, 1'b0, mk(36, 0, 1, 1, 32, 1), 10);

        // Abort mid-iteration.
        launch_mult_to(10);
        abort = 1'b1;
        #1;
        check_val("abort_clr", int'(sys_clr), 1);
        check_val("abort_iter_en", int'(iter_en), 0);
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_idx", int'(iter_idx), 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen = 1;
            @(negedge clk);
        end
        check_val("abort_no_done", int'(done_seen), 0);

        // Reset mid-iteration, then a clean restart.
        launch_mult_to(5);
        reset = 1'b0;
        #1;
        check_val("midop_reset_outs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midop_reset_no_clr", int'(sys_clr), 0);
        run_op("restart", OP_MULT, 1'b0, mk(36, 0, 1, 1, 32, 1), 0);

        check_val("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
